ex_flush_arb: RTL and testbench

Flush sequencer between commit-stage flush sources and the IFU. Accepts a branch-mispredict flush (from the branch-resolve path, as an adder operand pair) and an exception/interrupt flush (from the exception path, as a final PC), arbitrates them with exception priority, and presents one registered flush request with a stable target PC to the IFU until the IFU acknowledges. An exception flush that arrives while a branch flush is pending replaces it.

---
 rtl/ex_flush_arb.sv | 198 +++++++++++++++++++
 tb/tb_ex_flush_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flush_arb.sv
// ex_flush_arb
// Flush sequencer between the commit-stage flush sources and the IFU.
//
// Two requesters compete for the IFU flush path:
//   - the exception/irq path supplies a final target PC;
//   - the branch-resolve path supplies an adder operand pair whose sum,
//     modulo 2^PC_SIZE, is the target.
// Exceptions win ties. A single registered request with a stable PC/source
// is held toward the IFU until it acknowledges. An exception that arrives
// while a branch flush is still waiting for the IFU replaces that branch
// flush, and the replaced flush is never counted.
//
// Optional feature (compile-time macro E203_FLUSH_STATS_EN):
//   defined   -> saturating completion counters per source, cleared by cnt_clr
//   undefined -> counter outputs tied to zero, cnt_clr ignored
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   excp_flush_req/pc/ack    exception request, target PC, combinational accept
//   brch_flush_req/op1/op2   branch request and target adder operands
//   brch_flush_ack           combinational branch accept
//   ifu_flush_req/pc/src     registered flush toward IFU (src: 0 branch, 1 excp)
//   ifu_flush_ack            IFU accepts the flush
//   flush_busy               a flush is pending toward the IFU
//   cnt_clr                  synchronous clear of statistics counters
//   brch_flush_cnt           completed branch flushes
//   excp_flush_cnt           completed exception flushes

module ex_flush_arb #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               excp_flush_req,
  input  logic [PC_SIZE-1:0] excp_flush_pc,
  output logic               excp_flush_ack,
  input  logic               brch_flush_req,
  input  logic [PC_SIZE-1:0] brch_flush_op1,
  input  logic [PC_SIZE-1:0] brch_flush_op2,
  output logic               brch_flush_ack,
  output logic               ifu_flush_req,
  output logic [PC_SIZE-1:0] ifu_flush_pc,
  output logic               ifu_flush_src,
  input  logic               ifu_flush_ack,
  output logic               flush_busy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   brch_flush_cnt,
  output logic [CNT_W-1:0]   excp_flush_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e             state_r;
  logic               req_r;
  logic [PC_SIZE-1:0] pc_r;
  logic               src_r;

  logic [PC_SIZE-1:0] brch_pc_s;
  logic               excp_ack_s;
  logic               brch_ack_s;
  logic               hsk_s;

  // Branch target; the sum is truncated to PC_SIZE so the carry is dropped.
  assign brch_pc_s = brch_flush_op1 + brch_flush_op2;

  // A flush completes when the IFU takes the request we are presenting.
  assign hsk_s = req_r & ifu_flush_ack;

  // Accept decode: exception priority in IDLE, exception-only preemption of a
  // branch flush in REQ, nothing while reset is held or during IFU handshake.
  always_comb begin
    excp_ack_s = 1'b0;
    brch_ack_s = 1'b0;
    if (rst) begin
      excp_ack_s = 1'b0;
      brch_ack_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (excp_flush_req) begin
            excp_ack_s = 1'b1;
          end else if (brch_flush_req) begin
            brch_ack_s = 1'b1;
          end else begin
            excp_ack_s = 1'b0;
            brch_ack_s = 1'b0;
          end
        end
        ST_REQ: begin
          if (!ifu_flush_ack && !src_r && excp_flush_req) begin
            excp_ack_s = 1'b1;
          end else begin
            excp_ack_s = 1'b0;
          end
        end
        default: begin
          excp_ack_s = 1'b0;
          brch_ack_s = 1'b0;
        end
      endcase
    end
  end

  // Flush FSM with registered request, target PC and source toward the IFU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      pc_r    <= {PC_SIZE{1'b0}};
      src_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (excp_ack_s) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            pc_r    <= excp_flush_pc;
            src_r   <= 1'b1;
          end else if (brch_ack_s) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            pc_r    <= brch_pc_s;
            src_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ifu_flush_ack) begin
            // PC/src keep their last value; only the request drops.
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
          end else if (excp_ack_s) begin
            // Exception supersedes the waiting branch flush without a gap.
            pc_r  <= excp_flush_pc;
            src_r <= 1'b1;
          end else begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign excp_flush_ack = excp_ack_s;
  assign brch_flush_ack = brch_ack_s;
  assign ifu_flush_req  = req_r;
  assign ifu_flush_pc   = pc_r;
  assign ifu_flush_src  = src_r;
  assign flush_busy     = req_r;

`ifdef E203_FLUSH_STATS_EN
  logic [CNT_W-1:0] brch_cnt_r;
  logic [CNT_W-1:0] excp_cnt_r;

  // Saturating completion counters; clear wins over a same-cycle completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      brch_cnt_r <= {CNT_W{1'b0}};
      excp_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      brch_cnt_r <= {CNT_W{1'b0}};
      excp_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (hsk_s && !src_r && !(&brch_cnt_r)) begin
        brch_cnt_r <= brch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        brch_cnt_r <= brch_cnt_r;
      end
      if (hsk_s && src_r && !(&excp_cnt_r)) begin
        excp_cnt_r <= excp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        excp_cnt_r <= excp_cnt_r;
      end
    end
  end

  assign brch_flush_cnt = brch_cnt_r;
  assign excp_flush_cnt = excp_cnt_r;
`else
  // Statistics disabled: outputs are constant and the clear input is a no-op.
  logic unused_stats_s;
  assign unused_stats_s = &{1'b0, cnt_clr, hsk_s};
  assign brch_flush_cnt = {CNT_W{1'b0}};
  assign excp_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_flush_arb.sv
module tb_ex_flush_arb;

  localparam int PC_SIZE = 32;
  localparam int CNT_W   = 2;
`ifdef E203_FLUSH_STATS_EN
  localparam logic [1:0] CNT_SAT = 2'd3;
`else
  localparam logic [1:0] CNT_SAT = 2'd0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               excp_flush_req;
  logic [PC_SIZE-1:0] excp_flush_pc;
  logic               excp_flush_ack;
  logic               brch_flush_req;
  logic [PC_SIZE-1:0] brch_flush_op1;
  logic [PC_SIZE-1:0] brch_flush_op2;
  logic               brch_flush_ack;
  logic               ifu_flush_req;
  logic [PC_SIZE-1:0] ifu_flush_pc;
  logic               ifu_flush_src;
  logic               ifu_flush_ack;
  logic               flush_busy;
  logic               cnt_clr;
  logic [CNT_W-1:0]   brch_flush_cnt;
  logic [CNT_W-1:0]   excp_flush_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected IFU flushes, {src, pc}, in completion order.
  logic [32:0] exp_q[$];
  // Expected counter values, updated at the handshake.
  logic [1:0]  m_b = 2'd0;
  logic [1:0]  m_e = 2'd0;

  ex_flush_arb #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .excp_flush_req (excp_flush_req),
    .excp_flush_pc  (excp_flush_pc),
    .excp_flush_ack (excp_flush_ack),
    .brch_flush_req (brch_flush_req),
    .brch_flush_op1 (brch_flush_op1),
    .brch_flush_op2 (brch_flush_op2),
    .brch_flush_ack (brch_flush_ack),
    .ifu_flush_req  (ifu_flush_req),
    .ifu_flush_pc   (ifu_flush_pc),
    .ifu_flush_src  (ifu_flush_src),
    .ifu_flush_ack  (ifu_flush_ack),
    .flush_busy     (flush_busy),
    .cnt_clr        (cnt_clr),
    .brch_flush_cnt (brch_flush_cnt),
    .excp_flush_cnt (excp_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input logic [1:0] b, input logic [1:0] e);
    chk("brch_cnt", {30'd0, brch_flush_cnt}, {30'd0, b});
    chk("excp_cnt", {30'd0, excp_flush_cnt}, {30'd0, e});
  endtask

  // Scoreboard monitor: compare each IFU handshake against the queue head.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      m_b = 2'd0;
      m_e = 2'd0;
    end else begin
      e = 33'd0;
      if (ifu_flush_req && ifu_flush_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL hsk_unexpected: got pc 0x%08h src %0b, queue empty", ifu_flush_pc, ifu_flush_src);
        end else begin
          e = exp_q.pop_front();
          chk("hsk_pc", ifu_flush_pc, e[31:0]);
          chk("hsk_src", {31'd0, ifu_flush_src}, {31'd0, e[32]});
        end
      end
`ifdef E203_FLUSH_STATS_EN
      if (cnt_clr) begin
        m_b = 2'd0;
        m_e = 2'd0;
      end else if (ifu_flush_req && ifu_flush_ack) begin
        if (!e[32] && m_b != 2'd3) m_b = m_b + 2'd1;
        if (e[32] && m_e != 2'd3) m_e = m_e + 2'd1;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    excp_flush_req = 1'b0; excp_flush_pc = 32'd0;
    brch_flush_req = 1'b0; brch_flush_op1 = 32'd0; brch_flush_op2 = 32'd0;
    ifu_flush_ack = 1'b0; cnt_clr = 1'b0;
    step; step;
    // Reset state
    chk("rst_req", {31'd0, ifu_flush_req}, 32'd0);
    chk("rst_pc", ifu_flush_pc, 32'd0);
    chk("rst_src", {31'd0, ifu_flush_src}, 32'd0);
    chk("rst_busy", {31'd0, flush_busy}, 32'd0);
    chk_cnts(2'd0, 2'd0);
    rst = 1'b0;

    // Branch flush, IFU acks 3 cycles after request rises
    brch_flush_req = 1'b1; brch_flush_op1 = 32'h8000_0100; brch_flush_op2 = 32'h20;
    #1;
    chk("s1_brch_ack", {31'd0, brch_flush_ack}, 32'd1);
    chk("s1_excp_ack", {31'd0, excp_flush_ack}, 32'd0);
    exp_q.push_back({1'b0, 32'h8000_0120});
    step;
    brch_flush_req = 1'b0;
    chk("s1_req", {31'd0, ifu_flush_req}, 32'd1);
    chk("s1_busy", {31'd0, flush_busy}, 32'd1);
    chk("s1_pc", ifu_flush_pc, 32'h8000_0120);
    chk("s1_src", {31'd0, ifu_flush_src}, 32'd0);
    step; step;
    chk("s1_pc_hold", ifu_flush_pc, 32'h8000_0120);
    ifu_flush_ack = 1'b1;
    step;
    ifu_flush_ack = 1'b0;
    chk("s1_idle", {31'd0, ifu_flush_req}, 32'd0);
    chk_cnts(m_b, m_e);
    chk("s1_cnt_const", {30'd0, brch_flush_cnt}, {31'd0, CNT_SAT[0]});

    // Simultaneous requests: exception wins, branch served after
    excp_flush_req = 1'b1; excp_flush_pc = 32'h0000_0040;
    brch_flush_req = 1'b1; brch_flush_op1 = 32'h1000; brch_flush_op2 = 32'h4;
    #1;
    chk("s2_excp_ack", {31'd0, excp_flush_ack}, 32'd1);
    chk("s2_brch_ack", {31'd0, brch_flush_ack}, 32'd0);
    exp_q.push_back({1'b1, 32'h40});
    step;
    excp_flush_req = 1'b0;
    chk("s2_pc", ifu_flush_pc, 32'h40);
    chk("s2_src", {31'd0, ifu_flush_src}, 32'd1);
    chk("s2_brch_ack_req", {31'd0, brch_flush_ack}, 32'd0);
    step;
    ifu_flush_ack = 1'b1;
    #1;
    chk("s2_brch_ack_hsk", {31'd0, brch_flush_ack}, 32'd0);
    step;
    ifu_flush_ack = 1'b0;
    chk("s2_gap", {31'd0, ifu_flush_req}, 32'd0);
    chk("s2_brch_ack2", {31'd0, brch_flush_ack}, 32'd1);
    exp_q.push_back({1'b0, 32'h1004});
    step;
    brch_flush_req = 1'b0;
    chk("s2_rerise", {31'd0, ifu_flush_req}, 32'd1);
    chk("s2_pc2", ifu_flush_pc, 32'h1004);

    // Preemption of pending branch (0x1004) by exception 0x2000
    excp_flush_req = 1'b1; excp_flush_pc = 32'h2000;
    #1;
    chk("s3_excp_ack", {31'd0, excp_flush_ack}, 32'd1);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b1, 32'h2000});
    step;
    excp_flush_req = 1'b0;
    chk("s3_req", {31'd0, ifu_flush_req}, 32'd1);
    chk("s3_pc", ifu_flush_pc, 32'h2000);
    chk("s3_src", {31'd0, ifu_flush_src}, 32'd1);
    step;
    chk("s3_req_hold", {31'd0, ifu_flush_req}, 32'd1);
    ifu_flush_ack = 1'b1;
    step;
    ifu_flush_ack = 1'b0;
    chk_cnts(m_b, m_e);
    chk("s3_brch_cnt_const", {30'd0, brch_flush_cnt}, {31'd0, CNT_SAT[0]});
    chk("s3_excp_cnt_const", {30'd0, excp_flush_cnt}, {30'd0, CNT_SAT & 2'd2});

    // Wrap and exception arriving during branch handshake
    brch_flush_req = 1'b1; brch_flush_op1 = 32'hFFFF_FFFE; brch_flush_op2 = 32'h4;
    #1;
    chk("s4_brch_ack", {31'd0, brch_flush_ack}, 32'd1);
    exp_q.push_back({1'b0, 32'h2});
    step;
    brch_flush_req = 1'b0;
    chk("s4_wrap_pc", ifu_flush_pc, 32'h2);
    ifu_flush_ack = 1'b1;
    excp_flush_req = 1'b1; excp_flush_pc = 32'h300;
    #1;
    chk("s4_no_preempt", {31'd0, excp_flush_ack}, 32'd0);
    step;
    ifu_flush_ack = 1'b0;
    chk("s4_idle", {31'd0, ifu_flush_req}, 32'd0);
    chk("s4_excp_ack", {31'd0, excp_flush_ack}, 32'd1);
    exp_q.push_back({1'b1, 32'h300});
    step;
    excp_flush_req = 1'b0;
    chk("s4_pc", ifu_flush_pc, 32'h300);
    chk("s4_src", {31'd0, ifu_flush_src}, 32'd1);
    chk_cnts(m_b, m_e);

    // Reset while request pending
    rst = 1'b1;
    brch_flush_req = 1'b1; brch_flush_op1 = 32'h10; brch_flush_op2 = 32'h10;
    #1;
    chk("s5_ack_rst", {31'd0, brch_flush_ack | excp_flush_ack}, 32'd0);
    void'(exp_q.pop_back());
    step;
    chk("s5_req", {31'd0, ifu_flush_req}, 32'd0);
    chk("s5_pc", ifu_flush_pc, 32'd0);
    chk("s5_src", {31'd0, ifu_flush_src}, 32'd0);
    chk("s5_busy", {31'd0, flush_busy}, 32'd0);
    chk_cnts(2'd0, 2'd0);
    chk("s5_brch_ack_idle_rst", {31'd0, brch_flush_ack}, 32'd0);
    rst = 1'b0;
    #1;
    chk("s5_brch_ack", {31'd0, brch_flush_ack}, 32'd1);
    exp_q.push_back({1'b0, 32'h20});
    step;
    brch_flush_req = 1'b0;
    chk("s5_pc2", ifu_flush_pc, 32'h20);
    ifu_flush_ack = 1'b1;
    step;
    ifu_flush_ack = 1'b0;

    // Saturation: five more branch flushes
    for (int i = 0; i < 5; i++) begin
      brch_flush_req = 1'b1; brch_flush_op1 = 32'(i + 1) << 8; brch_flush_op2 = 32'h0;
      exp_q.push_back({1'b0, 32'(i + 1) << 8});
      step;
      brch_flush_req = 1'b0;
      step;
      ifu_flush_ack = 1'b1;
      step;
      ifu_flush_ack = 1'b0;
      chk_cnts(m_b, m_e);
    end
    chk("s6_sat", {30'd0, brch_flush_cnt}, {30'd0, CNT_SAT});

    // Clear coinciding with a completion
    brch_flush_req = 1'b1; brch_flush_op1 = 32'h4000; brch_flush_op2 = 32'h4;
    exp_q.push_back({1'b0, 32'h4004});
    step;
    brch_flush_req = 1'b0;
    ifu_flush_ack = 1'b1; cnt_clr = 1'b1;
    step;
    ifu_flush_ack = 1'b0; cnt_clr = 1'b0;
    chk("s6_clr_brch", {30'd0, brch_flush_cnt}, 32'd0);
    chk("s6_clr_excp", {30'd0, excp_flush_cnt}, 32'd0);
    step;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
